ysyx_23060077_trap_ctrl: RTL and testbench
==========================================

Name: ysyx_23060077_trap_ctrl

Overview:
Trap sequencer between the execute stage and the machine-mode CSR file. It accepts ECALL/MRET requests from EXU and drains outstanding fetch and memory transactions. It then issues exactly one single-cycle update strobe to the CSR file and redirects fetch to mtvec (ECALL) or mepc (MRET). It guarantees that the CSR side effects and the PC redirect happen once per trap, in a fixed order.

Parameters:
- DATA_WIDTH, 32, width of PC and CSR values.
- CNT_WIDTH, 32, width of optional trap counters.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- trap_valid  input  1  EXU presents a trap request.
- trap_ready  output  1  block can accept a request.
- trap_is_mret  input  1  1 = MRET, 0 = ECALL; sampled on accept.
- trap_pc  input  DATA_WIDTH  PC of trapping instruction; sampled on accept.
- ifu_busy  input  1  IFU has an outstanding bus transaction.
- lsu_busy  input  1  LSU has an outstanding bus transaction.
- flush  output  1  kill younger instructions and block new issue.
- csr_ecall_o  output  1  one-cycle ECALL strobe to CSR file.
- csr_mret_o  output  1  one-cycle MRET strobe to CSR file.
- csr_pc_o  output  DATA_WIDTH  PC to write into mepc, qualified by csr_ecall_o.
- csr_mtvec  input  DATA_WIDTH  current mtvec.
- csr_mepc  input  DATA_WIDTH  current mepc.
- redirect_valid  output  1  fetch redirect request.
- redirect_ready  input  1  IFU accepts redirect.
- redirect_pc  output  DATA_WIDTH  redirect target.
- ecall_cnt  output  CNT_WIDTH  ECALLs retired (optional feature).
- mret_cnt  output  CNT_WIDTH  MRETs retired (optional feature).

Behaviour:
- Clocking: clock is `clock`; reset is `reset`, synchronous, active-high.
- Reset: state = IDLE. All outputs are 0, except trap_ready = 1. The latched type and PC are cleared to 0.
- States: IDLE, DRAIN, COMMIT, REDIRECT; registered FSM with a 2-bit encoding.
- IDLE:
  - trap_ready = 1, flush = 0.
  - On trap_valid & trap_ready, latch trap_is_mret and trap_pc, then go to DRAIN.
- DRAIN:
  - flush = 1, trap_ready = 0.
  - If ifu_busy = 0 and lsu_busy = 0 in this cycle, go to COMMIT. Otherwise stay; there is no timeout.
- COMMIT:
  - Lasts exactly one cycle; flush = 1.
  - csr_ecall_o = ~latched_mret, csr_mret_o = latched_mret. Exactly one strobe is high.
  - csr_pc_o = latched PC while in COMMIT, 0 otherwise.
  - Next state is always REDIRECT. CSR registers update at the end of this cycle.
- REDIRECT:
  - flush = 1, redirect_valid = 1.
  - redirect_pc is taken combinationally from the CSR inputs: ECALL uses {csr_mtvec[DATA_WIDTH-1:2], 2'b00} (direct mode, mode bits masked); MRET uses csr_mepc.
  - redirect_valid and redirect_pc stay stable until redirect_ready. On redirect_valid & redirect_ready, go to IDLE.
- Minimum latency, accept cycle T with busy signals low: DRAIN at T+1, COMMIT at T+2, REDIRECT at T+3. trap_ready returns at T+4 at the earliest.
- A second request is never accepted while not in IDLE. trap_valid held high outside IDLE is ignored.
- Busy signals that rise again during COMMIT or REDIRECT are ignored; the drain check happens only in DRAIN.
- Reset in any state returns to IDLE on the next edge. A reset in COMMIT suppresses that cycle's strobe (reset has priority). No partial redirect is issued.
- redirect_pc and csr_pc_o are 0 outside REDIRECT and COMMIT respectively.

Optional Feature:
- Macro: YSYX_23060077_TRAP_CNT_EN.
- Defined: ecall_cnt and mret_cnt increment by 1 on the COMMIT cycle of the respective trap type. They reset to 0 and wrap modulo 2^CNT_WIDTH.
- Undefined: both ports are tied to 0 and no counter flops exist; all other behaviour is identical.

Test Plan:
- ECALL at trap_pc=0x8000_0100, csr_mtvec=0x8000_0403, busy low, redirect_ready=1:
  - csr_ecall_o high for exactly one cycle at T+2, with csr_pc_o=0x8000_0100.
  - redirect_pc=0x8000_0400 at T+3; trap_ready high at T+4.
- MRET with csr_mepc=0x8000_0104:
  - csr_mret_o pulse only, csr_ecall_o stays 0.
  - redirect_pc=0x8000_0104; flush high from T+1 through T+3.
- ECALL with lsu_busy high for 5 cycles after accept:
  - FSM holds DRAIN and no strobe appears.
  - COMMIT occurs the cycle after lsu_busy falls; flush stays high throughout.
- redirect_ready low for 3 cycles:
  - redirect_valid and redirect_pc remain stable and trap_ready stays 0.
  - A new trap_valid is not accepted until after the handshake.
- reset asserted in DRAIN and, separately, in COMMIT:
  - No CSR strobe fires; the next cycle shows IDLE with trap_ready=1 and all other outputs 0.
- With YSYX_23060077_TRAP_CNT_EN defined, run 3 ECALLs and 2 MRETs: ecall_cnt=3, mret_cnt=2. Preload near max to check wrap to 0.

Source files
------------

// File: rtl/ysyx_23060077_trap_ctrl.sv
// rtl/ysyx_23060077_trap_ctrl.sv - ECALL/MRET trap sequencer: drain, CSR commit strobe, fetch redirect
// Optional trap counters are enabled by defining YSYX_23060077_TRAP_CNT_EN.
module ysyx_23060077_trap_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  trap_valid,
    output logic                  trap_ready,
    input  logic                  trap_is_mret,
    input  logic [DATA_WIDTH-1:0] trap_pc,
    input  logic                  ifu_busy,
    input  logic                  lsu_busy,
    output logic                  flush,
    output logic                  csr_ecall_o,
    output logic                  csr_mret_o,
    output logic [DATA_WIDTH-1:0] csr_pc_o,
    input  logic [DATA_WIDTH-1:0] csr_mtvec,
    input  logic [DATA_WIDTH-1:0] csr_mepc,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0]  ecall_cnt,
    output logic [CNT_WIDTH-1:0]  mret_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  lat_mret;
    logic [DATA_WIDTH-1:0] lat_pc;
    logic                  commit_fire;

    // State register; reset wins from any state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture trap type and PC on the accept handshake only.
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_mret <= 1'b0;
            lat_pc   <= '0;
        end else if (trap_valid && trap_ready) begin
            lat_mret <= trap_is_mret;
            lat_pc   <= trap_pc;
        end
    end

    // Next-state and output decode; strobes and redirect are masked by reset
    // so a reset in the same cycle never produces a partial side effect.
    always_comb begin
        state_next     = state;
        trap_ready     = 1'b0;
        flush          = 1'b0;
        commit_fire    = 1'b0;
        csr_ecall_o    = 1'b0;
        csr_mret_o     = 1'b0;
        csr_pc_o       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            IDLE: begin
                trap_ready = 1'b1;
                if (trap_valid) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                flush = 1'b1;
                if (!ifu_busy && !lsu_busy) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                flush       = 1'b1;
                commit_fire = !reset;
                csr_ecall_o = commit_fire && !lat_mret;
                csr_mret_o  = commit_fire && lat_mret;
                csr_pc_o    = lat_pc;
                state_next  = REDIRECT;
            end
            REDIRECT: begin
                flush          = 1'b1;
                redirect_valid = !reset;
                redirect_pc    = lat_mret ? csr_mepc : {csr_mtvec[DATA_WIDTH-1:2], 2'b00};
                if (redirect_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef YSYX_23060077_TRAP_CNT_EN
    // Retired-trap counters, bumped on the committing cycle; wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            ecall_cnt <= '0;
            mret_cnt  <= '0;
        end else if (commit_fire) begin
            if (lat_mret) begin
                mret_cnt <= mret_cnt + 1'b1;
            end else begin
                ecall_cnt <= ecall_cnt + 1'b1;
            end
        end
    end
`else
    assign ecall_cnt = '0;
    assign mret_cnt  = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060077_trap_ctrl.sv
// tb/tb_ysyx_23060077_trap_ctrl.sv - self-checking bench for ysyx_23060077_trap_ctrl
module tb_ysyx_23060077_trap_ctrl;

    localparam int DW = 32;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          trap_valid;
    logic          trap_ready;
    logic          trap_is_mret;
    logic [DW-1:0] trap_pc;
    logic          ifu_busy;
    logic          lsu_busy;
    logic          flush;
    logic          csr_ecall_o;
    logic          csr_mret_o;
    logic [DW-1:0] csr_pc_o;
    logic [DW-1:0] csr_mtvec;
    logic [DW-1:0] csr_mepc;
    logic          redirect_valid;
    logic          redirect_ready;
    logic [DW-1:0] redirect_pc;
    logic [CW-1:0] ecall_cnt;
    logic [CW-1:0] mret_cnt;

    int tests = 0;
    int fails = 0;

    // Trap record: a trap in flight passes through "drained" then "committed".
    bit            m_have;
    bit            m_drained;
    bit            m_committed;
    bit            m_mret;
    logic [DW-1:0] m_pc;
    int            m_ecalls;
    int            m_mrets;

    // Output samples from the most recent step, for literal checks.
    logic          s_ready, s_flush, s_ecall, s_mret, s_rv;
    logic [DW-1:0] s_cpc, s_rpc;
    logic [CW-1:0] s_ecnt, s_mcnt;

    ysyx_23060077_trap_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .trap_valid(trap_valid), .trap_ready(trap_ready),
        .trap_is_mret(trap_is_mret), .trap_pc(trap_pc),
        .ifu_busy(ifu_busy), .lsu_busy(lsu_busy), .flush(flush),
        .csr_ecall_o(csr_ecall_o), .csr_mret_o(csr_mret_o), .csr_pc_o(csr_pc_o),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .ecall_cnt(ecall_cnt), .mret_cnt(mret_cnt)
    );

    always #5 clock = ~clock;

    function automatic int cnt_exp(input int n);
`ifdef YSYX_23060077_TRAP_CNT_EN
        return n % (1 << CW);
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic step();
        bit            e_strobe;
        logic [DW-1:0] e_rpc;
        #2;
        e_strobe = m_drained && !m_committed && !reset;
        e_rpc    = !m_committed ? '0 : (m_mret ? csr_mepc : (csr_mtvec & ~32'h3));
        s_ready = trap_ready; s_flush = flush; s_ecall = csr_ecall_o; s_mret = csr_mret_o;
        s_rv = redirect_valid; s_cpc = csr_pc_o; s_rpc = redirect_pc;
        s_ecnt = ecall_cnt; s_mcnt = mret_cnt;
        chk("trap_ready", {31'd0, trap_ready}, {31'd0, !m_have});
        chk("flush", {31'd0, flush}, {31'd0, m_have});
        chk("csr_ecall_o", {31'd0, csr_ecall_o}, {31'd0, e_strobe && !m_mret});
        chk("csr_mret_o", {31'd0, csr_mret_o}, {31'd0, e_strobe && m_mret});
        chk("csr_pc_o", csr_pc_o, (m_drained && !m_committed) ? m_pc : '0);
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_committed && !reset});
        chk("redirect_pc", redirect_pc, e_rpc);
        chk("ecall_cnt", DW'(ecall_cnt), DW'(cnt_exp(m_ecalls)));
        chk("mret_cnt", DW'(mret_cnt), DW'(cnt_exp(m_mrets)));
        @(posedge clock);
        if (reset) begin
            m_have = 0; m_drained = 0; m_committed = 0; m_mret = 0; m_pc = '0;
            m_ecalls = 0; m_mrets = 0;
        end else if (!m_have) begin
            if (trap_valid) begin
                m_have = 1; m_mret = trap_is_mret; m_pc = trap_pc;
            end
        end else if (!m_drained) begin
            if (!ifu_busy && !lsu_busy) m_drained = 1;
        end else if (!m_committed) begin
            m_committed = 1;
            if (m_mret) m_mrets++; else m_ecalls++;
        end else if (redirect_ready) begin
            m_have = 0; m_drained = 0; m_committed = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; trap_valid = 0; trap_is_mret = 0; trap_pc = '0;
        ifu_busy = 0; lsu_busy = 0; redirect_ready = 1;
    endtask

    // Full trap with busy low and immediate redirect acceptance.
    task automatic do_trap(input bit mret, input logic [DW-1:0] pc);
        trap_valid = 1; trap_is_mret = mret; trap_pc = pc;
        step();
        trap_valid = 0;
        step(); step(); step();
    endtask

    initial begin
        m_have = 0; m_drained = 0; m_committed = 0; m_mret = 0; m_pc = '0;
        m_ecalls = 0; m_mrets = 0;
        idle_inputs();
        csr_mtvec = 32'h8000_0403; csr_mepc = 32'h8000_0104;
        reset = 1;
        @(posedge clock); #1;
        step();
        reset = 0;
        step();
        chk("reset_ready", {31'd0, s_ready}, 32'd1);
        chk("reset_flush", {31'd0, s_flush}, 32'd0);
        chk("reset_rv", {31'd0, s_rv}, 32'd0);

        // ECALL, minimum latency.
        trap_valid = 1; trap_is_mret = 0; trap_pc = 32'h8000_0100;
        step();                                   // T
        trap_valid = 0;
        step();                                   // T+1
        chk("ecall_t1_flush", {31'd0, s_flush}, 32'd1);
        chk("ecall_t1_strobe", {31'd0, s_ecall}, 32'd0);
        step();                                   // T+2
        chk("ecall_t2_strobe", {31'd0, s_ecall}, 32'd1);
        chk("ecall_t2_pc", s_cpc, 32'h8000_0100);
        step();                                   // T+3
        chk("ecall_t3_strobe", {31'd0, s_ecall}, 32'd0);
        chk("ecall_t3_rpc", s_rpc, 32'h8000_0400);
        step();                                   // T+4
        chk("ecall_t4_ready", {31'd0, s_ready}, 32'd1);

        // MRET.
        trap_valid = 1; trap_is_mret = 1; trap_pc = 32'h8000_0200;
        step();
        trap_valid = 0;
        step();
        chk("mret_t1_flush", {31'd0, s_flush}, 32'd1);
        step();
        chk("mret_t2_mret", {31'd0, s_mret}, 32'd1);
        chk("mret_t2_ecall", {31'd0, s_ecall}, 32'd0);
        step();
        chk("mret_t3_rpc", s_rpc, 32'h8000_0104);
        chk("mret_t3_flush", {31'd0, s_flush}, 32'd1);
        step();

        // ECALL with LSU busy for 5 cycles after accept.
        trap_valid = 1; trap_is_mret = 0; trap_pc = 32'h8000_0300;
        step();
        trap_valid = 0; lsu_busy = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("busy_no_strobe", {31'd0, s_ecall}, 32'd0);
            chk("busy_flush", {31'd0, s_flush}, 32'd1);
        end
        lsu_busy = 0;
        step();
        chk("busy_drain_exit", {31'd0, s_ecall}, 32'd0);
        lsu_busy = 1;                              // ignored after drain
        step();
        chk("busy_commit", {31'd0, s_ecall}, 32'd1);
        chk("busy_commit_pc", s_cpc, 32'h8000_0300);
        lsu_busy = 0;

        // Redirect back-pressure; a pending trap_valid must not be taken.
        redirect_ready = 0; trap_valid = 1; trap_pc = 32'h8000_0500;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_rv", {31'd0, s_rv}, 32'd1);
            chk("bp_rpc", s_rpc, 32'h8000_0400);
            chk("bp_ready", {31'd0, s_ready}, 32'd0);
        end
        redirect_ready = 1;
        step();
        step();
        chk("bp_ready_after", {31'd0, s_ready}, 32'd1);
        trap_valid = 0;
        step(); step(); step();

        // Reset during DRAIN.
        trap_valid = 1; trap_is_mret = 0; trap_pc = 32'h8000_0600;
        step();
        trap_valid = 0; ifu_busy = 1;
        step();
        reset = 1;
        step();
        reset = 0; ifu_busy = 0;
        step();
        chk("rst_drain_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_drain_strobe", {31'd0, s_ecall}, 32'd0);

        // Reset during COMMIT.
        trap_valid = 1; trap_pc = 32'h8000_0700;
        step();
        trap_valid = 0;
        step();
        reset = 1;
        step();
        chk("rst_commit_strobe", {31'd0, s_ecall}, 32'd0);
        reset = 0;
        step();
        chk("rst_commit_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_commit_flush", {31'd0, s_flush}, 32'd0);
        chk("rst_commit_rv", {31'd0, s_rv}, 32'd0);

        // Counters: 3 ECALLs, 2 MRETs from reset, then one more ECALL wraps.
        do_trap(0, 32'h1000); do_trap(1, 32'h1004); do_trap(0, 32'h1008);
        do_trap(1, 32'h100c); do_trap(0, 32'h1010);
        step();
        chk("cnt_ecall3", DW'(s_ecnt), DW'(cnt_exp(3)));
        chk("cnt_mret2", DW'(s_mcnt), DW'(cnt_exp(2)));
        do_trap(0, 32'h1014);
        step();
        chk("cnt_ecall_wrap", DW'(s_ecnt), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 99) < 2);
            trap_valid     = $urandom_range(0, 1) == 1;
            trap_is_mret   = $urandom_range(0, 1) == 1;
            trap_pc        = $urandom;
            ifu_busy       = ($urandom_range(0, 9) < 3);
            lsu_busy       = ($urandom_range(0, 9) < 3);
            redirect_ready = $urandom_range(0, 1) == 1;
            csr_mtvec      = $urandom;
            csr_mepc       = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
